// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Shares one combinational 32-bit ALU between two requesters. A round-robin
//   arbiter accepts one operation at a time. It holds the operands in stable
//   registers that drive the ALU for EXEC_CYCLES cycles, then captures the
//   result and flags. The captured values go back on the issuing port's
//   response channel. Opcodes above MAX_OPCODE never reach the ALU; they are
//   answered at once with result 0 and flags 4'b1000.
//
// Parameters
//   EXEC_CYCLES  ALU settle cycles before capture (1..15)
//   MAX_OPCODE   highest legal opcode
//
// Ports
//   clock, reset_n                        clock, async active-low reset
//   reqN_valid/ready, reqN_opA/opB        per-port request channel
//   reqN_opcode/shamt
//   respN_valid/ready, respN_result/flags per-port response channel,
//                                         flags = {illegal, overflow,
//                                         isLessThan, isNotEqual}
//   alu_operandA/B, alu_opcode/shiftamt   registered ALU inputs
//   alu_result, alu_isNotEqual,           ALU outputs
//   alu_isLessThan, alu_overflow
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int unsigned EXEC_CYCLES = 1,
  parameter int unsigned MAX_OPCODE  = 5
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_opA,
  input  logic [31:0] req0_opB,
  input  logic [4:0]  req0_opcode,
  input  logic [4:0]  req0_shamt,
  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic [31:0] resp0_result,
  output logic [3:0]  resp0_flags,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_opA,
  input  logic [31:0] req1_opB,
  input  logic [4:0]  req1_opcode,
  input  logic [4:0]  req1_shamt,
  output logic        resp1_valid,
  input  logic        resp1_ready,
  output logic [31:0] resp1_result,
  output logic [3:0]  resp1_flags,
  output logic [31:0] alu_operandA,
  output logic [31:0] alu_operandB,
  output logic [4:0]  alu_opcode,
  output logic [4:0]  alu_shiftamt,
  input  logic [31:0] alu_result,
  input  logic        alu_isNotEqual,
  input  logic        alu_isLessThan,
  input  logic        alu_overflow
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);
  localparam logic [4:0] MAX_OP   = 5'(MAX_OPCODE);

  // Round-robin pick: a lone requester wins, a tie goes to the port that
  // was not granted last.
  function automatic logic pick_port(input logic v0, input logic v1,
                                     input logic last);
    logic win;
    case ({v1, v0})
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = ~last;
      default: win = 1'b0;
    endcase
    return win;
  endfunction

  logic [1:0]       state_r;
  logic [3:0]       cnt_r;
  logic             owner_r;
  logic             last_grant_r;
  logic [1:0]       resp_valid_r;
  logic [1:0][31:0] resp_result_r;
  logic [1:0][3:0]  resp_flags_r;

  logic        cand_s;
  logic        hs_s;
  logic        legal_s;
  logic        owner_ready_s;
  logic [31:0] sel_opA_s;
  logic [31:0] sel_opB_s;
  logic [4:0]  sel_opcode_s;
  logic [4:0]  sel_shamt_s;

  // Candidate selection, request handshake and operand mux for the winner.
  always_comb begin
    cand_s       = pick_port(req0_valid, req1_valid, last_grant_r);
    // Readiness is gated by reset_n so every output reads 0 while in reset.
    hs_s         = (state_r == ST_IDLE) & (req0_valid | req1_valid) & reset_n;
    req0_ready   = hs_s & ~cand_s;
    req1_ready   = hs_s & cand_s;
    if (cand_s) begin
      sel_opA_s    = req1_opA;
      sel_opB_s    = req1_opB;
      sel_opcode_s = req1_opcode;
      sel_shamt_s  = req1_shamt;
    end else begin
      sel_opA_s    = req0_opA;
      sel_opB_s    = req0_opB;
      sel_opcode_s = req0_opcode;
      sel_shamt_s  = req0_shamt;
    end
    legal_s       = (sel_opcode_s <= MAX_OP);
    owner_ready_s = owner_r ? resp1_ready : resp0_ready;
  end

  // Control FSM, ALU input registers and per-port response registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_IDLE;
      cnt_r         <= 4'd0;
      owner_r       <= 1'b0;
      last_grant_r  <= 1'b1;
      resp_valid_r  <= 2'b00;
      resp_result_r <= '0;
      resp_flags_r  <= '0;
      alu_operandA  <= 32'd0;
      alu_operandB  <= 32'd0;
      alu_opcode    <= 5'd0;
      alu_shiftamt  <= 5'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (hs_s) begin
            owner_r      <= cand_s;
            last_grant_r <= cand_s;
            if (legal_s) begin
              alu_operandA <= sel_opA_s;
              alu_operandB <= sel_opB_s;
              alu_opcode   <= sel_opcode_s;
              alu_shiftamt <= sel_shamt_s;
              cnt_r        <= CNT_INIT;
              state_r      <= ST_EXEC;
            end else begin
              // Illegal op: answer directly and leave the ALU inputs alone.
              resp_result_r[cand_s] <= 32'd0;
              resp_flags_r[cand_s]  <= 4'b1000;
              resp_valid_r[cand_s]  <= 1'b1;
              state_r               <= ST_RESP;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else begin
            resp_result_r[owner_r] <= alu_result;
            resp_flags_r[owner_r]  <= {1'b0, alu_overflow, alu_isLessThan,
                                       alu_isNotEqual};
            resp_valid_r[owner_r]  <= 1'b1;
            state_r                <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (owner_ready_s) begin
            resp_valid_r[owner_r] <= 1'b0;
            state_r               <= ST_IDLE;
          end else begin
            state_r <= ST_RESP;
          end
        end
        default: begin
          resp_valid_r <= 2'b00;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

  assign resp0_valid  = resp_valid_r[0];
  assign resp1_valid  = resp_valid_r[1];
  assign resp0_result = resp_result_r[0];
  assign resp1_result = resp_result_r[1];
  assign resp0_flags  = resp_flags_r[0];
  assign resp1_flags  = resp_flags_r[1];

endmodule
